// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers.
// Control-bundle bit offsets, per-stage width defaults and the
// main-slot load-source type used by the stage steering logic.
package pipe_pkg;

    // Control bundle layout (LSB offsets; two-bit fields noted)
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMTOREG = 3;  // [4:3]
    localparam int CTRL_REGDST   = 5;  // [6:5]

    // Per-stage defaults
    localparam int ID_EX_DATA_W  = 96;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int EX_MEM_DATA_W = 96;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 64;
    localparam int MEM_WB_CTRL_W = 8;
    localparam int DEF_CNT_W     = 16;

    // Where the main slot takes its next entry from
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IN   = 2'd1,
        SRC_SKID = 2'd2
    } main_src_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid bit plus control and data bundles.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clr_i        squash: drop the entry (data kept unless CLEAR_DATA)
//   load_i       capture ctrl_i/data_i and mark valid
//   drop_i       entry consumed, slot becomes a bubble
//   ctrl_i/data_i incoming bundles
//   valid_o/ctrl_o/data_o held entry
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W     = ID_EX_DATA_W,
    parameter int CTRL_W     = ID_EX_CTRL_W,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr_i || (drop_i && !load_i)) begin
            // Bubbles never carry stale control bits
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA) data_d = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, flush,
// optional two-entry skid buffering and a saturating stall counter.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 squash all held entries
//   in_valid/in_ready     upstream handshake, in_ctrl/in_data bundles
//   out_valid/out_ready   downstream handshake, out_ctrl/out_data bundles
//   stall_cnt             saturating count of out_valid & ~out_ready cycles
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = ID_EX_DATA_W,
    parameter int CTRL_W     = ID_EX_CTRL_W,
    parameter bit SKID       = 1'b1,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] main_data, skid_data, main_data_in;
    logic              in_xfer, drain;
    logic              main_load, main_drop;
    main_src_e         main_src;

    always_comb begin
        in_xfer  = in_valid & in_ready;
        drain    = main_v & out_ready;
        main_src = SRC_NONE;
        // A full skid always refills main first so order is preserved
        if (skid_v && drain)
            main_src = SRC_SKID;
        else if (in_xfer && (!main_v || drain))
            main_src = SRC_IN;
        main_load    = (main_src != SRC_NONE);
        main_drop    = drain & ~main_load;
        main_ctrl_in = (main_src == SRC_SKID) ? skid_ctrl : in_ctrl;
        main_data_in = (main_src == SRC_SKID) ? skid_data : in_data;
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .load_i  (main_load),
        .drop_i  (main_drop),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_v),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_load, skid_drop;
            // Ready depends only on the skid flop, not on out_ready
            assign in_ready  = ~flush & ~skid_v;
            assign skid_load = in_xfer & main_v & ~drain;
            assign skid_drop = skid_v & drain;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .clr_i   (flush),
                .load_i  (skid_load),
                .drop_i  (skid_drop),
                .ctrl_i  (in_ctrl),
                .data_i  (in_data),
                .valid_o (skid_v),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );
        end else begin : g_noskid
            assign in_ready  = ~flush & (out_ready | ~main_v);
            assign skid_v    = 1'b0;
            assign skid_ctrl = '0;
            assign skid_data = '0;
        end
    endgenerate

    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (main_v && !out_ready && stall_q != CNT_MAX)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 8;
    localparam int NW = 4;

    typedef logic [CW+DW-1:0] ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, flush = 1'b0, out_ready = 1'b1;
    logic          iv0 = 1'b0, iv1 = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          ir0, ir1, ov0, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [NW-1:0] sc0, sc1;

    logic          ir[2], ov[2];
    logic [CW-1:0] oc[2];
    logic [DW-1:0] od[2];
    logic [NW-1:0] sc[2];
    assign ir[0] = ir0; assign ir[1] = ir1;
    assign ov[0] = ov0; assign ov[1] = ov1;
    assign oc[0] = oc0; assign oc[1] = oc1;
    assign od[0] = od0; assign od[1] = od1;
    assign sc[0] = sc0; assign sc[1] = sc1;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CLEAR_DATA(1'b0), .CNT_W(NW)) u0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .stall_cnt(sc0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CLEAR_DATA(1'b0), .CNT_W(NW)) u1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .stall_cnt(sc1)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    ent_t q0[$];
    ent_t q1[$];
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] ctl(input int i);
        return 8'(8'h10 + i);
    endfunction

    function automatic logic [DW-1:0] dat(input int i);
        return {32'hDA7A0000 + 32'(i), 32'h0BAD0000 ^ 32'(i), 32'(i)};
    endfunction

    // Drive one cycle; record what each DUT accepts at the coming edge
    task automatic step(input logic r, input logic f, input logic v0, input logic v1,
                        input logic [CW-1:0] c, input logic [DW-1:0] d, input logic rdy);
        @(negedge clk);
        reset = r; flush = f; iv0 = v0; iv1 = v1;
        in_ctrl = c; in_data = d; out_ready = rdy;
        #1;
        if (r || f) begin
            q0.delete();
            q1.delete();
        end else begin
            if (v0 && ir0) q0.push_back({c, d});
            if (v1 && ir1) q1.push_back({c, d});
        end
    endtask

    logic          ph[2] = '{1'b0, 1'b0};
    ent_t          pe[2];
    logic [NW-1:0] sm[2] = '{4'd0, 4'd0};

    task automatic mon_one(input int k);
        ent_t got, e;
        logic empty;
        got = {oc[k], od[k]};
        if (!ov[k]) chk($sformatf("bubble_ctrl%0d", k), oc[k], 0);
        if (ph[k]) begin
            chk($sformatf("hold_valid%0d", k), ov[k], 1);
            chk($sformatf("hold_entry%0d", k), got, pe[k]);
        end
        chk($sformatf("stall_model%0d", k), sc[k], sm[k]);
        if (ov[k] && out_ready && !flush && !reset) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_vec++;
                n_bad++;
                $display("FAIL out_unexpected%0d: got %h expected no entry", k, got);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("out_entry%0d", k), got, e);
            end
        end
        ph[k] = ov[k] && !out_ready && !flush && !reset;
        pe[k] = got;
        if (reset)                                  sm[k] = '0;
        else if (ov[k] && !out_ready && sm[k] != '1) sm[k] = sm[k] + 1'b1;
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            mon_one(0);
            mon_one(1);
        end
    end

    initial begin
        // Reset with junk on the input
        step(1, 0, 1, 1, 8'hFF, '0, 1);
        step(1, 0, 1, 1, 8'hFF, '0, 1);
        mon_en = 1'b1;
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), ov[k], 0);
            chk($sformatf("rst_ctrl%0d", k), oc[k], 0);
            chk($sformatf("rst_stall%0d", k), sc[k], 0);
            chk($sformatf("rst_ready%0d", k), ir[k], 1);
        end

        // Streaming, one-cycle latency, no gaps
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1, ctl(i), dat(i), 1);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("strm_ready%0d", k), ir[k], 1);
                if (i > 0) begin
                    chk($sformatf("strm_valid%0d", k), ov[k], 1);
                    chk($sformatf("strm_entry%0d", k), {oc[k], od[k]}, {ctl(i-1), dat(i-1)});
                end
            end
        end
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++)
            chk($sformatf("strm_last%0d", k), {ov[k], od[k]}, {1'b1, dat(9)});
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("strm_empty%0d", k), ov[k], 0);
            chk($sformatf("strm_stall%0d", k), sc[k], 0);
        end

        // Backpressure: A accepted, B offered while stalled 3 cycles
        step(0, 0, 1, 1, ctl(20), dat(20), 1);
        chk("bp_a_ready0", ir0, 1);
        chk("bp_a_ready1", ir1, 1);
        step(0, 0, 1, 1, ctl(21), dat(21), 0);
        chk("bp_b_ready0", ir0, 0);
        chk("bp_b_ready1", ir1, 1);
        step(0, 0, 1, 1, ctl(21), dat(21), 0);
        chk("bp_full_ready0", ir0, 0);
        chk("bp_full_ready1", ir1, 0);
        step(0, 0, 1, 0, ctl(21), dat(21), 0);
        chk("bp_stall2_0", sc0, 2);
        chk("bp_stall2_1", sc1, 2);
        step(0, 0, 1, 0, ctl(21), dat(21), 1);
        chk("bp_rel_ready0", ir0, 1);
        chk("bp_rel_ready1", ir1, 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bp_out_a%0d", k), {ov[k], oc[k], od[k]}, {1'b1, ctl(20), dat(20)});
            chk($sformatf("bp_stall3_%0d", k), sc[k], 3);
        end
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++)
            chk($sformatf("bp_out_b%0d", k), {ov[k], oc[k], od[k]}, {1'b1, ctl(21), dat(21)});
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bp_drained%0d", k), ov[k], 0);
            chk($sformatf("bp_stall_end%0d", k), sc[k], 3);
        end

        // Flush with A held (+B in skid), C offered, out_ready high
        step(0, 0, 1, 1, ctl(30), dat(30), 1);
        step(0, 0, 1, 1, ctl(31), dat(31), 0);
        chk("fl_b_ready1", ir1, 1);
        step(0, 1, 1, 1, ctl(32), dat(32), 1);
        chk("fl_ready0", ir0, 0);
        chk("fl_ready1", ir1, 0);
        for (int k = 0; k < 2; k++) chk($sformatf("fl_stall%0d", k), sc[k], 4);
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++)
            chk($sformatf("fl_empty%0d", k), {ov[k], oc[k]}, 0);
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("fl_still_empty%0d", k), ov[k], 0);
            chk($sformatf("fl_stall_kept%0d", k), sc[k], 4);
        end

        // Saturation: 20 stalled cycles on a 4-bit counter
        step(0, 0, 1, 1, ctl(40), dat(40), 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, '0, '0, 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sat_cnt%0d", k), sc[k], 4'hF);
            chk($sformatf("sat_held%0d", k), {ov[k], od[k]}, {1'b1, dat(40)});
        end
        step(1, 0, 0, 0, '0, '0, 0);
        step(0, 0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sat_rst_cnt%0d", k), sc[k], 0);
            chk($sformatf("sat_rst_valid%0d", k), ov[k], 0);
        end

        // Random traffic against the scoreboard
        for (int n = 0; n < 4000; n++) begin
            logic f, v, r;
            f = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            step(0, f, v, v, 8'($urandom), {$urandom, $urandom, $urandom}, r);
        end
        repeat (4) step(0, 0, 0, 0, '0, '0, 1);
        chk("end_queue0", q0.size(), 0);
        chk("end_queue1", q1.size(), 0);
        chk("end_valid0", ov0, 0);
        chk("end_valid1", ov1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
